// File: rtl/nb_info_ram_ctrl.sv
// Client-side controller for the single-port neighbour-info RAM.
// Serialises top-neighbour reads and write-backs onto one RAM port.
// Holds a single buffered write and forwards it to a matching read.
// Read results appear a fixed three cycles after the request is accepted.
module nb_info_ram_ctrl #(
  parameter int                   ADDR_BITS   = 8,
  parameter int                   DATA_BITS   = 16,
  parameter logic [DATA_BITS-1:0] DEFAULT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // read request side
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_avail,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  // write-back side
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  // RAM port
  output logic                 ram_wr_n,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_data_in,
  input  logic [DATA_BITS-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // read context, captured when a read is accepted
  logic [ADDR_BITS-1:0] ra_addr;
  logic                 ra_avail;
  logic                 ra_byp;
  logic [DATA_BITS-1:0] ra_bypdata;

  // single-entry write buffer
  logic [ADDR_BITS-1:0] wb_addr;
  logic [DATA_BITS-1:0] wb_data;
  logic                 wr_pending;

  logic rd_accept;
  logic wr_accept;
  logic wr_drain;

  assign rd_accept = rd_req && (state == IDLE);
  assign wr_accept = wr_req && !wr_pending;
  // The buffered write goes to the RAM in WR, or piggybacks on the CAP
  // cycle, which does not need the port because the read data is already
  // on ram_data_out.
  assign wr_drain  = (state == WR) || ((state == CAP) && wr_pending);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a read takes priority over a pending write.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          state_nxt = RD;
        end else if (wr_pending) begin
          state_nxt = WR;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: handshakes and the RAM port, decoded from state and registers.
  always_comb begin
    rd_ready    = (state == IDLE);
    wr_ready    = !wr_pending;
    ram_wr_n    = !wr_drain;
    ram_addr    = wr_drain ? wb_addr : ra_addr;
    ram_data_in = wb_data;
  end

  // Capture read context; bypass only a write buffered before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_addr    <= '0;
      ra_avail   <= 1'b0;
      ra_byp     <= 1'b0;
      ra_bypdata <= '0;
    end else if (rd_accept) begin
      ra_addr    <= rd_addr;
      ra_avail   <= rd_avail;
      ra_byp     <= wr_pending && (wb_addr == rd_addr);
      ra_bypdata <= wb_data;
    end
  end

  // Write buffer: fill when empty, empty when the RAM write happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr    <= '0;
      wb_data    <= '0;
      wr_pending <= 1'b0;
    end else if (wr_accept) begin
      wb_addr    <= wr_addr;
      wb_data    <= wr_data;
      wr_pending <= 1'b1;
    end else if (wr_drain) begin
      wr_pending <= 1'b0;
    end
  end

  // Read result: select default / bypass / RAM data at the end of CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= (state == CAP);
      if (state == CAP) begin
        rd_data <= (!ra_avail) ? DEFAULT_VAL :
                   ra_byp      ? ra_bypdata  : ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_nb_info_ram_ctrl.sv
// Directed bench for nb_info_ram_ctrl with a registered single-port RAM model.
module tb_nb_info_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_avail;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        ram_wr_n;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;

  logic [15:0] mem [256];

  int n_cmp;
  int n_err;

  nb_info_ram_ctrl #(
    .ADDR_BITS  (8),
    .DATA_BITS  (16),
    .DEFAULT_VAL(16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_avail    (rd_avail),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .ram_wr_n    (ram_wr_n),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-first, registered output.
  always @(posedge clk) begin
    if (!ram_wr_n) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one read from an idle controller and return what was observed in
  // cycles 1..3 after the request; callers compare against expectations.
  task automatic read_txn(input logic [7:0] a, input logic av,
                          output logic [7:0] c1_addr, output logic c1_wrn,
                          output logic c1_ready, output logic c2_valid,
                          output logic c3_valid, output logic [15:0] c3_data);
    rd_req = 1'b1; rd_addr = a; rd_avail = av;
    step();
    rd_req = 1'b0;
    c1_addr = ram_addr; c1_wrn = ram_wr_n; c1_ready = rd_ready;
    step();
    c2_valid = rd_valid;
    step();
    c3_valid = rd_valid; c3_data = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_avail = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL reset_ram_wr_n got %b want 1", ram_wr_n); end
    n_cmp++; if (ram_addr !== 8'h00) begin n_err++; $display("FAIL reset_ram_addr got %h want 00", ram_addr); end
    n_cmp++; if (ram_data_in !== 16'h0000) begin n_err++; $display("FAIL reset_ram_data_in got %h want 0000", ram_data_in); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_rd_valid got %b want 0", rd_valid); end
  endtask

  task automatic test_write_read();
    logic [7:0] c1a; logic c1w, c1r, c2v, c3v; logic [15:0] c3d;
    wr_req = 1'b1; wr_addr = 8'd5; wr_data = 16'h1234;
    step();
    wr_req = 1'b0;
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL wr5_pending_ready got %b want 0", wr_ready); end
    n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL wr5_idle_wr_n got %b want 1", ram_wr_n); end
    step();
    n_cmp++; if (ram_wr_n !== 1'b0) begin n_err++; $display("FAIL wr5_wr_n got %b want 0", ram_wr_n); end
    n_cmp++; if (ram_addr !== 8'd5) begin n_err++; $display("FAIL wr5_addr got %h want 05", ram_addr); end
    n_cmp++; if (ram_data_in !== 16'h1234) begin n_err++; $display("FAIL wr5_data got %h want 1234", ram_data_in); end
    step();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr5_ready_after got %b want 1", wr_ready); end
    n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL wr5_wr_n_after got %b want 1", ram_wr_n); end
    n_cmp++; if (mem[5] !== 16'h1234) begin n_err++; $display("FAIL wr5_mem got %h want 1234", mem[5]); end
    step();
    read_txn(8'd5, 1'b1, c1a, c1w, c1r, c2v, c3v, c3d);
    n_cmp++; if (c1a !== 8'd5) begin n_err++; $display("FAIL rd5_c1_addr got %h want 05", c1a); end
    n_cmp++; if (c1w !== 1'b1) begin n_err++; $display("FAIL rd5_c1_wr_n got %b want 1", c1w); end
    n_cmp++; if (c1r !== 1'b0) begin n_err++; $display("FAIL rd5_c1_rd_ready got %b want 0", c1r); end
    n_cmp++; if (c2v !== 1'b0) begin n_err++; $display("FAIL rd5_c2_valid got %b want 0", c2v); end
    n_cmp++; if (c3v !== 1'b1) begin n_err++; $display("FAIL rd5_c3_valid got %b want 1", c3v); end
    n_cmp++; if (c3d !== 16'h1234) begin n_err++; $display("FAIL rd5_data got %h want 1234", c3d); end
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd5_pulse got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 16'h1234) begin n_err++; $display("FAIL rd5_hold got %h want 1234", rd_data); end
  endtask

  task automatic test_unavailable();
    logic [7:0] c1a; logic c1w, c1r, c2v, c3v; logic [15:0] c3d;
    mem[7] = 16'hBEEF;
    read_txn(8'd7, 1'b0, c1a, c1w, c1r, c2v, c3v, c3d);
    n_cmp++; if (c1a !== 8'd7) begin n_err++; $display("FAIL rd7na_c1_addr got %h want 07", c1a); end
    n_cmp++; if (c3v !== 1'b1) begin n_err++; $display("FAIL rd7na_valid got %b want 1", c3v); end
    n_cmp++; if (c3d !== 16'h0000) begin n_err++; $display("FAIL rd7na_data got %h want 0000", c3d); end
    read_txn(8'd7, 1'b1, c1a, c1w, c1r, c2v, c3v, c3d);
    n_cmp++; if (c3v !== 1'b1) begin n_err++; $display("FAIL rd7_valid got %b want 1", c3v); end
    n_cmp++; if (c3d !== 16'hBEEF) begin n_err++; $display("FAIL rd7_data got %h want beef", c3d); end
  endtask

  task automatic test_bypass();
    logic [7:0] c1a; logic c1w, c1r, c2v, c3v; logic [15:0] c3d;
    wr_req = 1'b1; wr_addr = 8'd3; wr_data = 16'hAAAA;
    step();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 8'd3; rd_avail = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL byp_rd_wr_n got %b want 1", ram_wr_n); end
    n_cmp++; if (ram_addr !== 8'd3) begin n_err++; $display("FAIL byp_rd_addr got %h want 03", ram_addr); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL byp_rd_wr_ready got %b want 0", wr_ready); end
    step();
    n_cmp++; if (ram_wr_n !== 1'b0) begin n_err++; $display("FAIL byp_cap_wr_n got %b want 0", ram_wr_n); end
    n_cmp++; if (ram_addr !== 8'd3) begin n_err++; $display("FAIL byp_cap_addr got %h want 03", ram_addr); end
    n_cmp++; if (ram_data_in !== 16'hAAAA) begin n_err++; $display("FAIL byp_cap_data got %h want aaaa", ram_data_in); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL byp_cap_valid got %b want 0", rd_valid); end
    step();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 16'hAAAA) begin n_err++; $display("FAIL byp_data got %h want aaaa", rd_data); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL byp_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (mem[3] !== 16'hAAAA) begin n_err++; $display("FAIL byp_mem got %h want aaaa", mem[3]); end
    read_txn(8'd3, 1'b1, c1a, c1w, c1r, c2v, c3v, c3d);
    n_cmp++; if (c3v !== 1'b1) begin n_err++; $display("FAIL rd3_valid got %b want 1", c3v); end
    n_cmp++; if (c3d !== 16'hAAAA) begin n_err++; $display("FAIL rd3_data got %h want aaaa", c3d); end
  endtask

  task automatic test_same_edge();
    mem[9] = 16'h0001;
    rd_req = 1'b1; rd_addr = 8'd9; rd_avail = 1'b1;
    wr_req = 1'b1; wr_addr = 8'd9; wr_data = 16'h0002;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL same_wr_ready got %b want 0", wr_ready); end
    n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL same_rd_wr_n got %b want 1", ram_wr_n); end
    step();
    n_cmp++; if (ram_wr_n !== 1'b0) begin n_err++; $display("FAIL same_cap_wr_n got %b want 0", ram_wr_n); end
    n_cmp++; if (ram_data_in !== 16'h0002) begin n_err++; $display("FAIL same_cap_data got %h want 0002", ram_data_in); end
    step();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL same_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 16'h0001) begin n_err++; $display("FAIL same_data got %h want 0001", rd_data); end
    n_cmp++; if (mem[9] !== 16'h0002) begin n_err++; $display("FAIL same_mem got %h want 0002", mem[9]); end
  endtask

  task automatic test_back_to_back();
    // two writes, second held while the first is buffered
    wr_req = 1'b1; wr_addr = 8'd20; wr_data = 16'h1111;
    step();
    wr_addr = 8'd21; wr_data = 16'h2222;
    step();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_wr_ready_held got %b want 0", wr_ready); end
    n_cmp++; if (ram_addr !== 8'd20) begin n_err++; $display("FAIL b2b_first_addr got %h want 14", ram_addr); end
    n_cmp++; if (ram_data_in !== 16'h1111) begin n_err++; $display("FAIL b2b_first_data got %h want 1111", ram_data_in); end
    step();
    n_cmp++; if (mem[20] !== 16'h1111) begin n_err++; $display("FAIL b2b_mem20 got %h want 1111", mem[20]); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_drained got %b want 1", wr_ready); end
    n_cmp++; if (mem[21] !== 16'h0000) begin n_err++; $display("FAIL b2b_mem21_early got %h want 0000", mem[21]); end
    step();
    wr_req = 1'b0;
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept got %b want 0", wr_ready); end
    step();
    n_cmp++; if (ram_wr_n !== 1'b0) begin n_err++; $display("FAIL b2b_second_wr_n got %b want 0", ram_wr_n); end
    n_cmp++; if (ram_addr !== 8'd21) begin n_err++; $display("FAIL b2b_second_addr got %h want 15", ram_addr); end
    step();
    n_cmp++; if (mem[21] !== 16'h2222) begin n_err++; $display("FAIL b2b_mem21 got %h want 2222", mem[21]); end
    n_cmp++; if (mem[20] !== 16'h1111) begin n_err++; $display("FAIL b2b_mem20_kept got %h want 1111", mem[20]); end
    // rd_req held through RD/CAP: exactly one extra read after rd_ready returns
    rd_req = 1'b1; rd_addr = 8'd20; rd_avail = 1'b1;
    step();
    n_cmp++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_rd_ready_rd got %b want 0", rd_ready); end
    step();
    rd_addr = 8'd21;
    n_cmp++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_rd_ready_cap got %b want 0", rd_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_cap got %b want 0", rd_valid); end
    step();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd1_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 16'h1111) begin n_err++; $display("FAIL b2b_rd1_data got %h want 1111", rd_data); end
    step();
    rd_req = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap1 got %b want 0", rd_valid); end
    n_cmp++; if (ram_addr !== 8'd21) begin n_err++; $display("FAIL b2b_rd2_addr got %h want 15", ram_addr); end
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap2 got %b want 0", rd_valid); end
    step();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd2_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 16'h2222) begin n_err++; $display("FAIL b2b_rd2_data got %h want 2222", rd_data); end
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_third got %b want 0", rd_valid); end
  endtask

  task automatic test_reset_mid();
    mem[40] = 16'h5555;
    wr_req = 1'b1; wr_addr = 8'd40; wr_data = 16'h6666;
    step();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 8'd40; rd_avail = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    n_cmp++; if (ram_wr_n !== 1'b0) begin n_err++; $display("FAIL rstm_cap_drain got %b want 0", ram_wr_n); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rstm_valid got %b want 0", rd_valid); end
    n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL rstm_wr_n got %b want 1", ram_wr_n); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rstm_wr_ready got %b want 1", wr_ready); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rstm_no_valid[%0d] got %b want 0", i, rd_valid); end
      n_cmp++; if (ram_wr_n !== 1'b1) begin n_err++; $display("FAIL rstm_no_write[%0d] got %b want 1", i, ram_wr_n); end
    end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rstm_ready_after got %b want 1", wr_ready); end
    n_cmp++; if (mem[40] !== 16'h5555) begin n_err++; $display("FAIL rstm_mem got %h want 5555", mem[40]); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_unavailable();
    test_bypass();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nb_info_ram_ctrl.md
Name: nb_info_ram_ctrl

Overview:
- Client-side controller for the single-port synchronous neighbour-info RAM, which stores intra4x4_pred_mode, ref_idx and mvp per macroblock column.
- Accepts top-neighbour read requests and current-MB write-back requests from the prediction pipeline.
- Sequences the shared RAM port, holds one buffered write and bypasses that write to a matching read.
- Returns read data with fixed latency, substituting a default value when the top neighbour is unavailable.

Parameters:
- ADDR_BITS, 8, RAM address width (MB column index).
- DATA_BITS, 16, RAM word width.
- DEFAULT_VAL, 0, value returned when the neighbour is unavailable.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rd_req  input  1  read request; accepted on an edge where rd_ready=1.
- rd_addr  input  ADDR_BITS  read address (mb_x).
- rd_avail  input  1  0 = neighbour unavailable; return DEFAULT_VAL.
- rd_ready  output  1  high when state is IDLE.
- rd_valid  output  1  one-cycle pulse marking rd_data valid.
- rd_data  output  DATA_BITS  read result; registered; held until the next rd_valid.
- wr_req  input  1  write request; accepted on an edge where wr_ready=1.
- wr_addr  input  ADDR_BITS  write address.
- wr_data  input  DATA_BITS  write data.
- wr_ready  output  1  equals !wr_pending.
- ram_wr_n  output  1  RAM write enable, active low.
- ram_addr  output  ADDR_BITS  RAM address.
- ram_data_in  output  DATA_BITS  RAM write data.
- ram_data_out  input  DATA_BITS  RAM registered read data; valid the cycle after the address is presented.

Behaviour:
- Reset values: state=IDLE, wr_pending=0, rd_valid=0, rd_data=0, ram_wr_n=1, ram_addr=0, ram_data_in=0.
- Reset mid-operation: any in-flight read and buffered write are discarded and no rd_valid is issued.
- Registers:
  - read context: ra_addr, ra_avail, ra_byp, ra_bypdata.
  - write buffer: wb_addr, wb_data, wr_pending.
- States: IDLE, RD, CAP, WR.
- IDLE:
  - rd_req accepted -> RD; latch rd_addr and rd_avail into ra_*.
  - Bypass: ra_byp = wr_pending && (wb_addr == rd_addr), with ra_bypdata = wb_data.
  - Otherwise, if wr_pending -> WR.
  - Otherwise stay in IDLE.
  - The read has priority over a pending write.
- RD: ram_wr_n=1, ram_addr=ra_addr. Always -> CAP.
- CAP:
  - rd_data <= (!ra_avail) ? DEFAULT_VAL : ra_byp ? ra_bypdata : ram_data_out.
  - rd_valid=1 in the following cycle.
  - If wr_pending at cycle start, the write drains this cycle: ram_wr_n=0, ram_addr=wb_addr, ram_data_in=wb_data, and wr_pending clears at the cycle-end edge.
  - -> IDLE.
- WR: ram_wr_n=0, ram_addr=wb_addr, ram_data_in=wb_data; clear wr_pending; -> IDLE.
- RAM port outputs are combinational from state and registers. In IDLE: ram_wr_n=1 and ram_addr holds ra_addr.
- Read latency:
  - rd_req high in cycle 0 -> ram_addr presented in cycle 1 -> ram_data_out valid in cycle 2 -> rd_valid=1 in cycle 3.
  - The latency is identical when unavailable or bypassed; the RAM read cycle is still spent.
- Read throughput is one read per 3 cycles; rd_ready is low during RD and CAP.
- Write acceptance:
  - wr_req is accepted when wr_pending=0, independent of state, and sets wr_pending.
  - Because wr_ready is registered, no write is accepted on the same edge that clears pending.
  - wr_req while wr_ready=0 is ignored; the source must hold it.
- Write visibility:
  - A write accepted on the same edge as a read is not visible to that read; it returns old RAM data or DEFAULT.
  - Only writes pending before the accept edge are bypassed.
- rd_req while rd_ready=0 is ignored.
- Write data reaches the RAM no later than 2 cycles after acceptance when no read intervenes.

Test Plan:
- Reset, then write addr 5 = 0x1234, idle, then read addr 5 with rd_avail=1 -> WR cycle shows ram_wr_n=0/addr 5/data 0x1234; rd_valid 3 cycles after rd_req with rd_data=0x1234.
- Read addr 7 with rd_avail=0 after RAM holds 0xBEEF at 7 -> rd_valid at cycle 3 with rd_data=DEFAULT_VAL (0); read addr 7 with rd_avail=1 -> 0xBEEF.
- Write addr 3 = 0xAAAA accepted, then rd_req addr 3 on the next edge while still pending -> read wins; rd_data=0xAAAA via bypass; the write drains during CAP (ram_wr_n=0 in cycle 2); a later read of 3 returns 0xAAAA from RAM.
- rd_req and wr_req on the same edge, both addr 9, RAM[9]=0x0001, wr_data=0x0002 -> rd_data=0x0001; RAM[9]=0x0002 afterwards.
- Second wr_req held while wr_ready=0 -> accepted only after the first write drains; both words land in RAM in order; rd_req held during RD/CAP is ignored until rd_ready=1.
- Assert rst_n low during CAP with a write pending -> rd_valid stays 0, ram_wr_n=1, wr_ready=1 after release, and the RAM location is unmodified.
